id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_pkg.sv | 35 +++
 rtl/id_ex_hazard.sv | 27 ++
 rtl/id_ex_stage.sv | 99 +++++++++
 tb/tb_id_ex_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pkg.sv
// Shared widths, the decode control word and ALU opcodes for the ID/EX boundary.
// Pure declarations: no latency, no flow control.
package id_ex_pkg;

  localparam int XLEN   = 32;
  localparam int SEL_W  = 5;
  localparam int CTRL_W = 8;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLL  = 4'h2,
    ALU_SLT  = 4'h3,
    ALU_SLTU = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_OR   = 4'h8,
    ALU_AND  = 4'h9,
    ALU_LUI  = 4'hA,
    ALU_PASS = 4'hB
  } alu_op_e;

  // Bit order matters: the stage is loaded and compared as a raw 8-bit word.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_hazard.sv
// Load-use detector: flags an ID instruction that reads the register an EX load is still fetching.
// Purely combinational, zero latency; no flow control of its own.
module id_ex_hazard #(
  parameter int SEL_W = id_ex_pkg::SEL_W
) (
  input  logic             id_valid,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [SEL_W-1:0] ex_rd_sel,
  input  logic [SEL_W-1:0] id_rs1_sel,
  input  logic             id_rs1_used,
  input  logic [SEL_W-1:0] id_rs2_sel,
  input  logic             id_rs2_used,
  output logic             hz
);

  logic ex_load;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hard-wired, so a load targeting it never blocks a consumer.
  assign ex_load = ex_valid & ex_mem_read & (ex_rd_sel != '0);
  assign rs1_hit = id_rs1_used & (id_rs1_sel == ex_rd_sel);
  assign rs2_hit = id_rs2_used & (id_rs2_sel == ex_rd_sel);
  assign hz      = id_valid & ex_load & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and writeback refresh while frozen.
// Latency 1 cycle; hold_i freezes the stage, stall_o (combinational) freezes PC and IF/ID.
module id_ex_stage #(
  parameter int XLEN  = id_ex_pkg::XLEN,
  parameter int SEL_W = id_ex_pkg::SEL_W
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               id_valid_i,
  input  logic [XLEN-1:0]    id_pc_i,
  input  logic [XLEN-1:0]    id_rd1_i,
  input  logic [XLEN-1:0]    id_rd2_i,
  input  logic [XLEN-1:0]    id_imm_i,
  input  logic [SEL_W-1:0]   id_rs1_sel_i,
  input  logic [SEL_W-1:0]   id_rs2_sel_i,
  input  logic [SEL_W-1:0]   id_rd_sel_i,
  input  logic               id_rs1_used_i,
  input  logic               id_rs2_used_i,
  input  id_ex_pkg::ctrl_t   id_ctrl_i,
  input  logic               hold_i,
  input  logic               flush_i,
  input  logic               wb_we_i,
  input  logic [SEL_W-1:0]   wb_sel_i,
  input  logic [XLEN-1:0]    wb_data_i,
  output logic               ex_valid_o,
  output logic [XLEN-1:0]    ex_pc_o,
  output logic [XLEN-1:0]    ex_rd1_o,
  output logic [XLEN-1:0]    ex_rd2_o,
  output logic [XLEN-1:0]    ex_imm_o,
  output logic [SEL_W-1:0]   ex_rs1_sel_o,
  output logic [SEL_W-1:0]   ex_rs2_sel_o,
  output logic [SEL_W-1:0]   ex_rd_sel_o,
  output id_ex_pkg::ctrl_t   ex_ctrl_o,
  output logic               stall_o
);

  import id_ex_pkg::*;

  logic hz;
  logic wb_live;
  logic refresh_rs1;
  logic refresh_rs2;

  id_ex_hazard #(
    .SEL_W (SEL_W)
  ) u_hazard (
    .id_valid    (id_valid_i),
    .ex_valid    (ex_valid_o),
    .ex_mem_read (ex_ctrl_o.mem_read),
    .ex_rd_sel   (ex_rd_sel_o),
    .id_rs1_sel  (id_rs1_sel_i),
    .id_rs1_used (id_rs1_used_i),
    .id_rs2_sel  (id_rs2_sel_i),
    .id_rs2_used (id_rs2_used_i),
    .hz          (hz)
  );

  // A redirect kills whatever is in ID, so nothing upstream needs freezing.
  assign stall_o = (hold_i | hz) & ~flush_i;

  // The held operands were read before this writeback landed; pick it up so EX sees fresh data.
  assign wb_live     = wb_we_i & (wb_sel_i != '0);
  assign refresh_rs1 = wb_live & (wb_sel_i == ex_rs1_sel_o);
  assign refresh_rs2 = wb_live & (wb_sel_i == ex_rs2_sel_o);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_valid_o   <= 1'b0;
      ex_pc_o      <= '0;
      ex_rd1_o     <= '0;
      ex_rd2_o     <= '0;
      ex_imm_o     <= '0;
      ex_rs1_sel_o <= '0;
      ex_rs2_sel_o <= '0;
      ex_rd_sel_o  <= '0;
      ex_ctrl_o    <= CTRL_NOP;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
      ex_ctrl_o  <= CTRL_NOP;
    end else if (hold_i) begin
      if (refresh_rs1) ex_rd1_o <= wb_data_i;
      if (refresh_rs2) ex_rd2_o <= wb_data_i;
    end else if (hz) begin
      ex_valid_o <= 1'b0;
      ex_ctrl_o  <= CTRL_NOP;
    end else begin
      ex_valid_o   <= id_valid_i;
      ex_pc_o      <= id_pc_i;
      ex_rd1_o     <= id_rd1_i;
      ex_rd2_o     <= id_rd2_i;
      ex_imm_o     <= id_imm_i;
      ex_rs1_sel_o <= id_rs1_sel_i;
      ex_rs2_sel_o <= id_rs2_sel_i;
      ex_rd_sel_o  <= id_rd_sel_i;
      ex_ctrl_o    <= id_valid_i ? id_ctrl_i : CTRL_NOP;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, multi-cycle corner sequences, then
// randomized traffic against a next-state reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1_sel, id_rs2_sel, id_rd_sel;
  logic        id_rs1_used, id_rs2_used;
  logic [7:0]  id_ctrl;
  logic        hold, flush;
  logic        wb_we;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1_sel, ex_rs2_sel, ex_rd_sel;
  logic [7:0]  ex_ctrl;
  logic        stall;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .id_valid_i    (id_valid),
    .id_pc_i       (id_pc),
    .id_rd1_i      (id_rd1),
    .id_rd2_i      (id_rd2),
    .id_imm_i      (id_imm),
    .id_rs1_sel_i  (id_rs1_sel),
    .id_rs2_sel_i  (id_rs2_sel),
    .id_rd_sel_i   (id_rd_sel),
    .id_rs1_used_i (id_rs1_used),
    .id_rs2_used_i (id_rs2_used),
    .id_ctrl_i     (id_ctrl),
    .hold_i        (hold),
    .flush_i       (flush),
    .wb_we_i       (wb_we),
    .wb_sel_i      (wb_sel),
    .wb_data_i     (wb_data),
    .ex_valid_o    (ex_valid),
    .ex_pc_o       (ex_pc),
    .ex_rd1_o      (ex_rd1),
    .ex_rd2_o      (ex_rd2),
    .ex_imm_o      (ex_imm),
    .ex_rs1_sel_o  (ex_rs1_sel),
    .ex_rs2_sel_o  (ex_rs2_sel),
    .ex_rd_sel_o   (ex_rd_sel),
    .ex_ctrl_o     (ex_ctrl),
    .stall_o       (stall)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        hold, flush, vld;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [7:0]  ctrl;
    logic [31:0] pc, rd1;
    logic        e_stall, e_vld;
    logic [7:0]  e_ctrl;
    logic [31:0] e_pc, e_rd1;
  } vec_t;

  function automatic vec_t mk(input logic h, f, v, input logic [4:0] r1, r2, rd,
                              input logic u1, u2, input logic [7:0] c,
                              input logic [31:0] pc, rd1,
                              input logic es, ev, input logic [7:0] ec,
                              input logic [31:0] epc, erd1);
    vec_t t;
    t.hold = h; t.flush = f; t.vld = v; t.rs1 = r1; t.rs2 = r2; t.rd = rd;
    t.u1 = u1; t.u2 = u2; t.ctrl = c; t.pc = pc; t.rd1 = rd1;
    t.e_stall = es; t.e_vld = ev; t.e_ctrl = ec; t.e_pc = epc; t.e_rd1 = erd1;
    return t;
  endfunction

  task automatic drive(input logic v, input logic [4:0] r1, r2, rd, input logic u1, u2,
                       input logic [7:0] c, input logic [31:0] pc, rd1, rd2, imm);
    id_valid = v; id_rs1_sel = r1; id_rs2_sel = r2; id_rd_sel = rd;
    id_rs1_used = u1; id_rs2_used = u2; id_ctrl = c;
    id_pc = pc; id_rd1 = rd1; id_rd2 = rd2; id_imm = imm;
  endtask

  // Reference EX state, advanced from the stage's update rules.
  typedef struct {
    logic        valid;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [7:0]  ctrl;
  } ex_t;

  ex_t m;

  function automatic logic model_hz(input ex_t s);
    logic reads_rd;
    reads_rd = (id_rs1_used && id_rs1_sel == s.rd) || (id_rs2_used && id_rs2_sel == s.rd);
    return id_valid && s.valid && s.ctrl[6] && (s.rd != 0) && reads_rd;
  endfunction

  function automatic ex_t model_next(input ex_t s);
    ex_t n;
    logic hz;
    n  = s;
    hz = model_hz(s);
    if (flush || (!hold && hz)) begin
      n.valid = 1'b0;
      n.ctrl  = 8'h00;
    end else if (hold) begin
      if (wb_we && wb_sel != 0 && wb_sel == s.rs1) n.rd1 = wb_data;
      if (wb_we && wb_sel != 0 && wb_sel == s.rs2) n.rd2 = wb_data;
    end else begin
      n.valid = id_valid;
      n.pc = id_pc; n.rd1 = id_rd1; n.rd2 = id_rd2; n.imm = id_imm;
      n.rs1 = id_rs1_sel; n.rs2 = id_rs2_sel; n.rd = id_rd_sel;
      n.ctrl = id_valid ? id_ctrl : 8'h00;
    end
    return n;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, " valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, " pc"}, ex_pc, 32'd0);
    chk({tag, " rd1"}, ex_rd1, 32'd0);
    chk({tag, " rd2"}, ex_rd2, 32'd0);
    chk({tag, " imm"}, ex_imm, 32'd0);
    chk({tag, " sels"}, {17'd0, ex_rs1_sel, ex_rs2_sel, ex_rd_sel}, 32'd0);
    chk({tag, " ctrl"}, {24'd0, ex_ctrl}, 32'd0);
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = mk(0,0,1, 1,2,3,   1,1, 8'h41, 32'h100, 32'hAAAA5555, 0,1,8'h41,32'h100,32'hAAAA5555);
    tbl[1] = mk(0,0,1, 1,2,5,   1,1, 8'hC0, 32'h104, 32'h11,       0,1,8'hC0,32'h104,32'h11);
    tbl[2] = mk(0,0,1, 6,5,7,   1,1, 8'h80, 32'h108, 32'h22,       1,0,8'h00,32'h104,32'h11);
    tbl[3] = mk(0,0,1, 6,5,7,   1,1, 8'h80, 32'h108, 32'h22,       0,1,8'h80,32'h108,32'h22);
    tbl[4] = mk(0,0,1, 1,2,0,   1,1, 8'h40, 32'h10C, 32'h33,       0,1,8'h40,32'h10C,32'h33);
    tbl[5] = mk(0,0,1, 0,0,5,   1,1, 8'h40, 32'h110, 32'h44,       0,1,8'h40,32'h110,32'h44);
    tbl[6] = mk(0,0,1, 1,5,9,   1,0, 8'h40, 32'h114, 32'h55,       0,1,8'h40,32'h114,32'h55);
    tbl[7] = mk(1,1,1, 9,0,10,  1,0, 8'h40, 32'h118, 32'h66,       0,0,8'h00,32'h114,32'h55);
    tbl[8] = mk(0,0,0, 1,2,3,   1,1, 8'hFF, 32'h200, 32'h77,       0,0,8'h00,32'h200,32'h77);

    rst_n = 1'b0; hold = 0; flush = 0; wb_we = 0; wb_sel = 0; wb_data = 0;
    drive(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    #2;
    chk_all_zero("reset");
    chk("reset stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      hold = tbl[i].hold; flush = tbl[i].flush;
      drive(tbl[i].vld, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].u1, tbl[i].u2,
            tbl[i].ctrl, tbl[i].pc, tbl[i].rd1, tbl[i].rd1 + 32'd1, tbl[i].pc ^ 32'hF0);
      #1;
      chk($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, tbl[i].e_stall});
      @(posedge clk); #1;
      chk($sformatf("v%0d valid", i), {31'd0, ex_valid}, {31'd0, tbl[i].e_vld});
      chk($sformatf("v%0d ctrl", i), {24'd0, ex_ctrl}, {24'd0, tbl[i].e_ctrl});
      chk($sformatf("v%0d pc", i), ex_pc, tbl[i].e_pc);
      chk($sformatf("v%0d rd1", i), ex_rd1, tbl[i].e_rd1);
    end
    hold = 0; flush = 0;

    // Three-cycle hold with a writeback to rs1 in the middle cycle.
    drive(1, 7, 8, 1, 1, 1, 8'h80, 32'h300, 32'h1, 32'h2, 32'h3);
    @(posedge clk); #1;
    hold = 1;
    drive(1, 7, 8, 12, 1, 1, 8'hC4, 32'h999, 32'h9, 32'h9, 32'h9);
    for (int c = 0; c < 3; c++) begin
      wb_we = (c == 1); wb_sel = (c == 1) ? 5'd7 : 5'd8; wb_data = (c == 1) ? 32'hDEADBEEF : 32'h5A5A5A5A;
      #1;
      chk($sformatf("hold c%0d stall", c), {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
    end
    wb_we = 0;
    chk("hold rd1", ex_rd1, 32'hDEADBEEF);
    chk("hold rd2", ex_rd2, 32'h2);
    chk("hold pc", ex_pc, 32'h300);
    chk("hold imm", ex_imm, 32'h3);
    chk("hold valid", {31'd0, ex_valid}, 32'd1);
    chk("hold ctrl", {24'd0, ex_ctrl}, 32'h80);
    chk("hold rd_sel", {27'd0, ex_rd_sel}, 32'd1);

    // Both operands refreshed by one writeback.
    hold = 0;
    drive(1, 4, 4, 2, 1, 1, 8'h80, 32'h310, 32'h5, 32'h6, 32'h0);
    @(posedge clk); #1;
    hold = 1; wb_we = 1; wb_sel = 4; wb_data = 32'h0BADF00D;
    @(posedge clk); #1;
    chk("dual rd1", ex_rd1, 32'h0BADF00D);
    chk("dual rd2", ex_rd2, 32'h0BADF00D);

    // Select 0 never refreshes.
    hold = 0; wb_we = 0;
    drive(1, 0, 0, 2, 1, 1, 8'h80, 32'h320, 32'h5, 32'h6, 32'h0);
    @(posedge clk); #1;
    hold = 1; wb_we = 1; wb_sel = 0; wb_data = 32'h99;
    @(posedge clk); #1;
    chk("sel0 rd1", ex_rd1, 32'h5);
    chk("sel0 rd2", ex_rd2, 32'h6);

    // Asynchronous reset between edges, then a normal first update.
    hold = 0; wb_we = 0;
    drive(1, 1, 2, 3, 1, 1, 8'h41, 32'h400, 32'h123, 32'h456, 32'h789);
    @(posedge clk); #1;
    chk("prerst valid", {31'd0, ex_valid}, 32'd1);
    @(negedge clk);
    rst_n = 0; hold = 1;
    #1;
    chk_all_zero("async rst");
    chk("rst stall", {31'd0, stall}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1; hold = 0;
    drive(1, 1, 2, 3, 1, 1, 8'h22, 32'h500, 32'h1, 32'h2, 32'h3);
    @(posedge clk); #1;
    chk("postrst pc", ex_pc, 32'h500);
    chk("postrst valid", {31'd0, ex_valid}, 32'd1);
    chk("postrst ctrl", {24'd0, ex_ctrl}, 32'h22);

    // Randomized traffic against the reference model.
    @(negedge clk);
    rst_n = 0;
    m = '{default: '0};
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 8'($urandom),
            $urandom, $urandom, $urandom, $urandom);
      hold    = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      wb_we   = 1'($urandom);
      wb_sel  = 5'($urandom_range(0, 3));
      wb_data = $urandom;
      #1;
      chk($sformatf("rnd%0d stall", i), {31'd0, stall},
          {31'd0, (hold || model_hz(m)) && !flush});
      @(posedge clk);
      m = model_next(m);
      #1;
      chk($sformatf("rnd%0d valid", i), {31'd0, ex_valid}, {31'd0, m.valid});
      chk($sformatf("rnd%0d pc", i), ex_pc, m.pc);
      chk($sformatf("rnd%0d rd1", i), ex_rd1, m.rd1);
      chk($sformatf("rnd%0d rd2", i), ex_rd2, m.rd2);
      chk($sformatf("rnd%0d imm", i), ex_imm, m.imm);
      chk($sformatf("rnd%0d sels", i), {17'd0, ex_rs1_sel, ex_rs2_sel, ex_rd_sel},
          {17'd0, m.rs1, m.rs2, m.rd});
      chk($sformatf("rnd%0d ctrl", i), {24'd0, ex_ctrl}, {24'd0, m.ctrl});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
